// File: rtl/neural_param_loader_pkg.sv
// neural_param_loader_pkg: shared constants and FSM encoding for the layer parameter loader
package neural_param_loader_pkg;
    localparam int WIDTH   = 16;
    localparam int NWORDS  = 6;
    localparam int IDX_CAA = 0;
    localparam int IDX_CAB = 1;
    localparam int IDX_CBA = 2;
    localparam int IDX_CBB = 3;
    localparam int IDX_B1  = 4;
    localparam int IDX_B2  = 5;
    localparam logic [WIDTH-1:0] ONE = 16'h0100;
    typedef enum logic {ST_LOAD = 1'b0, ST_DRAIN = 1'b1} state_e;
endpackage

// File: rtl/neural_param_bank.sv
// neural_param_bank: shadow register file with indexed write and parallel read
module neural_param_bank #(
    parameter int WIDTH  = neural_param_loader_pkg::WIDTH,
    parameter int NWORDS = neural_param_loader_pkg::NWORDS,
    parameter int IW     = $clog2(NWORDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we_i,
    input  logic [IW-1:0]                 idx_i,
    input  logic [WIDTH-1:0]              data_i,
    output logic [NWORDS-1:0][WIDTH-1:0]  rd_o
);
    logic [NWORDS-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else if (we_i) mem_q[idx_i] <= data_i;
    end

    assign rd_o = mem_q;
endmodule

// File: rtl/neural_param_loader.sv
// neural_param_loader: collects a six-word Q8.8 frame into a shadow bank and
// commits it atomically to the active bank driving the layer.
module neural_param_loader #(
    parameter int WIDTH  = neural_param_loader_pkg::WIDTH,
    parameter int NWORDS = neural_param_loader_pkg::NWORDS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] cAA,
    output logic [WIDTH-1:0] cAB,
    output logic [WIDTH-1:0] cBA,
    output logic [WIDTH-1:0] cBB,
    output logic [WIDTH-1:0] b1,
    output logic [WIDTH-1:0] b2,
    output logic             params_valid,
    output logic             update,
    output logic             err,
    output logic [7:0]       err_count
);
    import neural_param_loader_pkg::*;
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic ready_q, pv_q, pv_d, upd_q, err_q, err_d, commit, wr_en, acc;
    logic [7:0] cnt_q, cnt_d;
    logic [NWORDS-1:0][WIDTH-1:0] shadow, active_q, active_d;

    neural_param_bank #(.WIDTH(WIDTH), .NWORDS(NWORDS)) u_bank (
        .clk    (CLK),
        .rst    (RST),
        .we_i   (wr_en),
        .idx_i  (idx_q),
        .data_i (in_data),
        .rd_o   (shadow)
    );

    assign acc = in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        commit  = 1'b0;
        err_d   = 1'b0;
        wr_en   = acc && state_q == ST_LOAD;
        if (acc) begin
            if (state_q == ST_DRAIN) begin
                if (in_last) state_d = ST_LOAD;
            end else if (idx_q == LAST_IDX) begin
                idx_d = '0;
                if (in_last) commit = 1'b1;
                else begin
                    state_d = ST_DRAIN;
                    err_d   = 1'b1;
                end
            end else if (in_last) begin
                idx_d = '0;
                err_d = 1'b1;
            end else idx_d = idx_q + IW'(1);
        end
        // last word bypasses the shadow so the commit lands on the accepting edge
        active_d = commit ? {in_data, shadow[NWORDS-2:0]} : active_q;
        pv_d     = pv_q || commit;
        cnt_d    = (err_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_LOAD;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            active_q <= '0;
            pv_q     <= 1'b0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ready_q  <= 1'b1;
            active_q <= active_d;
            pv_q     <= pv_d;
            upd_q    <= commit;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready     = ready_q;
    assign cAA          = active_q[IDX_CAA];
    assign cAB          = active_q[IDX_CAB];
    assign cBA          = active_q[IDX_CBA];
    assign cBB          = active_q[IDX_CBB];
    assign b1           = active_q[IDX_B1];
    assign b2           = active_q[IDX_B2];
    assign params_valid = pv_q;
    assign update       = upd_q;
    assign err          = err_q;
    assign err_count    = cnt_q;
endmodule

// File: tb/tb_neural_param_loader.sv
// tb_neural_param_loader: directed frames with hand-computed active-bank and error expectations
module tb_neural_param_loader;
    import neural_param_loader_pkg::*;

    logic        CLK = 1'b0, RST = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic        in_ready, params_valid, update, err;
    logic [15:0] cAA, cAB, cBA, cBB, b1, b2;
    logic [7:0]  err_count;
    int checks = 0, failures = 0, upd_n = 0, err_n = 0;

    neural_param_loader dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .cAA(cAA), .cAB(cAB), .cBA(cBA), .cBB(cBB), .b1(b1), .b2(b2),
        .params_valid(params_valid), .update(update), .err(err), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (update) upd_n++;
        if (err) err_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l, input int gap);
        repeat (gap) tick();
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic bank(input string tag, input logic [95:0] exp);
        chk({tag, "_cAA"}, cAA, exp[95:80]);
        chk({tag, "_cAB"}, cAB, exp[79:64]);
        chk({tag, "_cBA"}, cBA, exp[63:48]);
        chk({tag, "_cBB"}, cBB, exp[47:32]);
        chk({tag, "_b1"},  b1,  exp[31:16]);
        chk({tag, "_b2"},  b2,  exp[15:0]);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ready", in_ready, 0);
        bank("rst", '0);
        chk("rst_pv", params_valid, 0);
        chk("rst_cnt", err_count, 0);
        RST = 1'b0;
        tick();
        chk("ready_up", in_ready, 1);

        for (int i = 0; i < 6; i++) send(i < 2 ? ONE : 16'h0000, i == 5, 0);
        bank("f1", {ONE, ONE, 16'h0, 16'h0, 16'h0, 16'h0});
        chk("f1_upd", update, 1);
        chk("f1_pv", params_valid, 1);
        tick();
        chk("f1_upd_off", update, 0);
        chk("f1_upd_n", upd_n, 1);

        for (int i = 0; i < 5; i++) send(i < 2 ? 16'hFFFF : ONE, 1'b0, $urandom_range(0, 3));
        chk("f2_hold_cAA", cAA, ONE);
        chk("f2_hold_cBB", cBB, 16'h0);
        send(ONE, 1'b1, 2);
        bank("f2", {16'hFFFF, 16'hFFFF, ONE, ONE, ONE, ONE});
        chk("f2_upd", update, 1);

        send(16'h1111, 1'b0, 0);
        send(16'h2222, 1'b0, 0);
        send(16'h3333, 1'b1, 0);
        chk("short_err", err, 1);
        chk("short_cnt", err_count, 1);
        chk("short_upd", update, 0);
        bank("short", {16'hFFFF, 16'hFFFF, ONE, ONE, ONE, ONE});
        for (int i = 1; i <= 6; i++) send(16'(i), i == 6, 0);
        bank("after_short", {16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6});
        chk("after_short_err", err, 0);

        for (int i = 0; i < 6; i++) send(16'hA0 + 16'(i), 1'b0, 0);
        chk("long_err", err, 1);
        chk("long_cnt", err_count, 2);
        chk("long_upd", update, 0);
        send(16'hA6, 1'b0, 0);
        chk("long_err_once", err, 0);
        send(16'hA7, 1'b1, 1);
        chk("long_drop_upd", update, 0);
        bank("long", {16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6});
        for (int i = 0; i < 6; i++) send(16'h10 + 16'(i), i == 5, 0);
        bank("after_long", {16'h10, 16'h11, 16'h12, 16'h13, 16'h14, 16'h15});
        chk("upd_total", upd_n, 3);
        chk("err_total", err_n, 2);

        for (int i = 0; i < 4; i++) send(16'h55, 1'b0, 0);
        RST = 1'b1;
        #1;
        bank("midrst", '0);
        chk("midrst_pv", params_valid, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_cnt", err_count, 0);
        tick();
        RST = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) send(i == 5 ? 16'h9 : 16'h7, i == 5, 0);
        bank("fresh", {16'h7, 16'h7, 16'h7, 16'h7, 16'h7, 16'h9});
        chk("fresh_pv", params_valid, 1);

        for (int i = 0; i < 254; i++) send(16'hBEEF, 1'b1, 0);
        chk("sat_fe", err_count, 8'hFE);
        for (int i = 0; i < 46; i++) send(16'hBEEF, 1'b1, 0);
        chk("sat_ff", err_count, 8'hFF);
        chk("sat_cAA", cAA, 16'h7);
        chk("sat_pv", params_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
